// File: rtl/sent_rx_data_unpack.sv
// SENT fast-channel unpacker: packs variable-width F1/F2 frame data MSB-first
// into per-channel bit accumulators and emits bytes to the RX FIFOs.
module sent_rx_data_unpack (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_valid,
  input  logic [15:0] data_f1,
  input  logic [11:0] data_f2,
  input  logic [1:0]  mode_f1,
  input  logic [1:0]  mode_f2,
  input  logic        flush,
  input  logic        full_f1,
  input  logic        full_f2,
  output logic        write_enable_f1,
  output logic        write_enable_f2,
  output logic [7:0]  data_out_f1,
  output logic [7:0]  data_out_f2,
  output logic        ready,
  output logic        overflow
);

  logic [23:0] r_acc_f1;
  logic [23:0] r_acc_f2;
  logic [4:0]  r_cnt_f1;
  logic [4:0]  r_cnt_f2;
  logic        r_we_f1;
  logic        r_we_f2;
  logic [7:0]  r_dout_f1;
  logic [7:0]  r_dout_f2;
  logic        r_overflow;

  logic [4:0]  w_width_f1;
  logic [4:0]  w_width_f2;
  logic        w_accept;
  logic        w_drop;
  logic        w_emit_f1;
  logic        w_emit_f2;
  logic [23:0] w_append_f1;
  logic [23:0] w_append_f2;

  function automatic logic [4:0] width_of_f1(input logic [1:0] mode);
    case (mode)
      2'b00:   width_of_f1 = 5'd12;
      2'b01:   width_of_f1 = 5'd14;
      2'b10:   width_of_f1 = 5'd16;
      default: width_of_f1 = 5'd0;
    endcase
  endfunction

  function automatic logic [4:0] width_of_f2(input logic [1:0] mode);
    case (mode)
      2'b00:   width_of_f2 = 5'd8;
      2'b01:   width_of_f2 = 5'd10;
      2'b10:   width_of_f2 = 5'd12;
      default: width_of_f2 = 5'd0;
    endcase
  endfunction

  // Valid bits live left-justified in acc; new data lands directly below them.
  // Accepting needs cnt < 8, so the shift 24-w-cnt never goes negative.
  function automatic logic [23:0] append_bits(input logic [23:0] acc,
                                              input logic [4:0]  cnt,
                                              input logic [15:0] data,
                                              input logic [4:0]  width);
    logic [23:0] mask;
    logic [4:0]  sh;
    mask = ~(24'hFF_FFFF << width);
    sh   = 5'd24 - width - cnt;
    append_bits = acc | (({8'h00, data} & mask) << sh);
  endfunction

  assign w_width_f1  = width_of_f1(mode_f1);
  assign w_width_f2  = width_of_f2(mode_f2);
  assign ready       = (r_cnt_f1 < 5'd8) && (r_cnt_f2 < 5'd8);
  assign w_accept    = frame_valid && ready && !flush;
  assign w_drop      = frame_valid && !ready && !flush;
  assign w_emit_f1   = (r_cnt_f1 >= 5'd8) && !full_f1;
  assign w_emit_f2   = (r_cnt_f2 >= 5'd8) && !full_f2;
  assign w_append_f1 = append_bits(r_acc_f1, r_cnt_f1, data_f1, w_width_f1);
  assign w_append_f2 = append_bits(r_acc_f2, r_cnt_f2, {4'h0, data_f2}, w_width_f2);

  // Channel F1: accept and emit are mutually exclusive because ready needs cnt < 8.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc_f1  <= 24'h0;
      r_cnt_f1  <= 5'd0;
      r_we_f1   <= 1'b0;
      r_dout_f1 <= 8'h00;
    end else if (flush) begin
      r_acc_f1  <= 24'h0;
      r_cnt_f1  <= 5'd0;
      r_we_f1   <= 1'b0;
    end else if (w_accept && (w_width_f1 != 5'd0)) begin
      r_acc_f1  <= w_append_f1;
      r_cnt_f1  <= r_cnt_f1 + w_width_f1;
      r_we_f1   <= 1'b0;
    end else if (w_emit_f1) begin
      r_dout_f1 <= r_acc_f1[23:16];
      r_acc_f1  <= r_acc_f1 << 8;
      r_cnt_f1  <= r_cnt_f1 - 5'd8;
      r_we_f1   <= 1'b1;
    end else begin
      r_we_f1   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc_f2  <= 24'h0;
      r_cnt_f2  <= 5'd0;
      r_we_f2   <= 1'b0;
      r_dout_f2 <= 8'h00;
    end else if (flush) begin
      r_acc_f2  <= 24'h0;
      r_cnt_f2  <= 5'd0;
      r_we_f2   <= 1'b0;
    end else if (w_accept && (w_width_f2 != 5'd0)) begin
      r_acc_f2  <= w_append_f2;
      r_cnt_f2  <= r_cnt_f2 + w_width_f2;
      r_we_f2   <= 1'b0;
    end else if (w_emit_f2) begin
      r_dout_f2 <= r_acc_f2[23:16];
      r_acc_f2  <= r_acc_f2 << 8;
      r_cnt_f2  <= r_cnt_f2 - 5'd8;
      r_we_f2   <= 1'b1;
    end else begin
      r_we_f2   <= 1'b0;
    end
  end

  // Sticky drop flag; only flush or reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  assign write_enable_f1 = r_we_f1;
  assign write_enable_f2 = r_we_f2;
  assign data_out_f1     = r_dout_f1;
  assign data_out_f2     = r_dout_f2;
  assign overflow        = r_overflow;

endmodule

// File: doc/sent_rx_data_unpack.md
SENT_RX_DATA_UNPACK -- requirements
Module: sent_rx_data_unpack

Interface
REQ-001 Parameters: none; all widths fixed as listed.
REQ-002 clk  input  1  system clock; all state updates on posedge clk only.
REQ-003 reset  input  1  reset, asynchronous, active-high; clock clk.
REQ-004 frame_valid  input  1  single-cycle pulse; data_f1/data_f2 hold one decoded fast-channel frame.
REQ-005 data_f1  input  16  fast channel 1 data, right-justified; only bits [W1-1:0] used.
REQ-006 data_f2  input  12  fast channel 2 data, right-justified; only bits [W2-1:0] used.
REQ-007 mode_f1  input  2  00=12-bit, 01=14-bit, 10=16-bit, 11=channel disabled.
REQ-008 mode_f2  input  2  00=8-bit, 01=10-bit, 10=12-bit, 11=channel disabled.
REQ-009 flush  input  1  synchronous clear of both accumulators and sticky flags.
REQ-010 full_f1 / full_f2  input  1 each  RX FIFO full, per channel.
REQ-011 write_enable_f1 / write_enable_f2  output  1 each  registered single-cycle FIFO write strobe.
REQ-012 data_out_f1 / data_out_f2  output  8 each  registered byte, valid while matching write_enable high.
REQ-013 ready  output  1  high when a frame_valid pulse in this cycle will be accepted.
REQ-014 overflow  output  1  sticky: a frame arrived while ready was low.

Function
REQ-015 Per channel: 24-bit accumulator acc, 5-bit bit count cnt (0..23); bits MSB-first, data_fx[Wx-1] enters first.
REQ-016 ready = (cnt_f1 < 8) AND (cnt_f2 < 8), combinational from registered state.
REQ-017 frame_valid with ready high: each enabled channel appends Wx bits below the cnt valid bits; cnt += Wx at that edge; disabled channel unchanged.
REQ-018 frame_valid with ready low: frame dropped, no accumulator change, overflow set to 1 at the edge.
REQ-019 Emission: each edge where cnt_x >= 8 and full_x low -> data_out_x = top 8 valid bits, write_enable_x = 1, cnt_x -= 8; else write_enable_x = 0, data_out_x holds.
REQ-020 Max one byte per channel per cycle; channels emit independently, same cycle allowed.
REQ-021 Latency: frame accepted at edge N -> first byte strobe visible after edge N+1; 16-bit f1 emits bytes after edges N+1, N+2 with full_f1 low.
REQ-022 Accepting a frame and emitting a byte on the same edge cannot occur for a channel (ready implies cnt < 8); no simultaneous append/remove logic required.
REQ-023 full_x high: byte held in acc, no strobe; emission resumes on first edge with full_x low; no data loss or duplication.
REQ-024 Remainder bits (cnt < 8) persist across frames: 12-bit packs 2 frames -> 3 bytes; 14-bit 4 frames -> 7 bytes; 10-bit 4 frames -> 5 bytes; 16-bit and 8-bit have no remainder.
REQ-025 flush: cnt_f1, cnt_f2, acc, overflow cleared to 0, write strobes 0 at that edge; flush beats frame_valid on the same edge (frame discarded, overflow not set).
REQ-026 mode_f1/mode_f2 changes are legal only with flush asserted or both cnt = 0; behaviour otherwise undefined and not verified.

Reset
REQ-027 reset high: acc=0, cnt=0, write_enable_f1/f2=0, data_out_f1/f2=8'h00, overflow=0, hence ready=1, immediately and asynchronously.
REQ-028 reset asserted mid-emission: pending bytes discarded; first post-reset strobe only after a new accepted frame.

Verification
REQ-029 mode_f1=00, mode_f2=11, frames 0xABC then 0xDEF, full low -> data_out_f1 bytes 0xAB, 0xCD, 0xEF; no f2 strobes.
REQ-030 mode_f2=01, frames 0x3FF, 0x000, 0x2AA, 0x155 -> f2 bytes 0xFF, 0xC0, 0x0A, 0xA9, 0x55, cnt_f2=0 after.
REQ-031 mode_f1=01, frames 0x3FFF, 0, 0, 0 -> f1 bytes 0xFF, 0xFC, 0x00, 0x00, 0x00, 0x00, 0x00.
REQ-032 mode_f1=10, frame 0x1234 with full_f1 high 3 cycles -> no strobe while full; then 0x12, 0x34 on consecutive cycles; second frame_valid during stall -> dropped, overflow=1, ready=0.
REQ-033 flush and frame_valid same cycle, cnt_f1=4 -> cnt 0, no strobes, overflow 0; reset asserted between bytes of 16-bit frame -> no further strobes, outputs 0.
